// File: rtl/multi_sel_rx.sv
// -----------------------------------------------------------------------------
// multi_sel_rx
//
// Receive-side decoder for the 4-beat scaled-product stream of the multi_sel
// shift-multiplier. A frame is d, d*3, d*7, d*8, with in_grant marking beat 0.
// The operand is recovered from beat 0. Every beat is checked against a
// shift-add reconstruction of that operand. One result is returned per frame,
// together with a per-beat error mask.
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   asynchronous reset, active low
//   in_grant  in   frame start, high on the beat-0 cycle only
//   din       in   product beat [OW-1:0], sampled every rising edge
//   d_out     out  recovered operand [DW-1:0], held between frames
//   d_valid   out  one-cycle pulse, d_out and err_mask are valid
//   err_mask  out  bit k set = beat k mismatched
//   sync_err  out  one-cycle pulse, current frame aborted by an early grant
// -----------------------------------------------------------------------------
module multi_sel_rx #(
    parameter int DW = 8,
    parameter int OW = DW + 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_grant,
    input  logic [OW-1:0] din,
    output logic [DW-1:0] d_out,
    output logic          d_valid,
    output logic [3:0]    err_mask,
    output logic          sync_err
);

    // The state encoding doubles as the index of the beat expected this cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B1   = 2'd1,
        B2   = 2'd2,
        B3   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_d;
    logic [DW-1:0] w_d_nxt;
    logic [3:0]    r_mask;
    logic [3:0]    w_mask_nxt;
    logic [DW-1:0] w_d_out_nxt;
    logic [3:0]    w_err_mask_nxt;
    logic          w_d_valid_nxt;
    logic          w_sync_err_nxt;

    // References are built at full beat width so that d*8 never truncates.
    logic [OW-1:0] w_d_ext;
    logic [OW-1:0] w_ref_x3;
    logic [OW-1:0] w_ref_x7;
    logic [OW-1:0] w_ref_x8;
    logic          w_hi_nz;
    logic          w_beat_err;
    logic [3:0]    w_mask_acc;

    assign w_d_ext  = OW'(r_d);
    assign w_ref_x3 = (w_d_ext << 1) + w_d_ext;
    assign w_ref_x7 = (w_d_ext << 3) - w_d_ext;
    assign w_ref_x8 =  w_d_ext << 3;

    // Beat 0 is the raw operand, so any bit above DW means it was corrupted.
    assign w_hi_nz = |din[OW-1:DW];

    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // first, so no path through the block leaves it unassigned (which would
        // infer a latch).
        w_beat_err = 1'b0;
        case (r_state)
            IDLE: w_beat_err = w_hi_nz;
            B1:   w_beat_err = (din != w_ref_x3);
            B2:   w_beat_err = (din != w_ref_x7);
            B3:   w_beat_err = (din != w_ref_x8);
            default: w_beat_err = 1'b0;
        endcase
    end

    // Running mask with the current beat's result folded in.
    assign w_mask_acc = r_mask | (w_beat_err ? (4'b0001 << r_state) : 4'b0000);

    always_comb begin
        w_state_nxt    = r_state;
        w_d_nxt        = r_d;
        w_mask_nxt     = r_mask;
        w_d_out_nxt    = d_out;
        w_err_mask_nxt = err_mask;
        w_d_valid_nxt  = 1'b0;
        w_sync_err_nxt = 1'b0;

        if (in_grant) begin
            // A grant always starts a new frame. Outside IDLE it aborts the
            // frame in flight; the published d_out/err_mask stay untouched.
            w_d_nxt        = din[DW-1:0];
            w_mask_nxt     = {3'b000, w_hi_nz};
            w_state_nxt    = B1;
            w_sync_err_nxt = (r_state != IDLE);
        end else begin
            case (r_state)
                IDLE: begin
                    // Without a grant the bus carries nothing of interest.
                end
                B1: begin
                    w_mask_nxt  = w_mask_acc;
                    w_state_nxt = B2;
                end
                B2: begin
                    w_mask_nxt  = w_mask_acc;
                    w_state_nxt = B3;
                end
                B3: begin
                    w_d_out_nxt    = r_d;
                    w_err_mask_nxt = w_mask_acc;
                    w_d_valid_nxt  = 1'b1;
                    w_mask_nxt     = 4'b0000;
                    w_state_nxt    = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_d      <= '0;
            r_mask   <= 4'b0000;
            d_out    <= '0;
            err_mask <= 4'b0000;
            d_valid  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_d      <= w_d_nxt;
            r_mask   <= w_mask_nxt;
            d_out    <= w_d_out_nxt;
            err_mask <= w_err_mask_nxt;
            d_valid  <= w_d_valid_nxt;
            sync_err <= w_sync_err_nxt;
        end
    end

endmodule
